// File: rtl/kl_ram_target.sv
// kl_ram_target: single-port 64-bit RAM target with burst writes and reads.
// Requests arrive on a valid/ready channel. Write bursts are acknowledged
// with one response beat. Read bursts return one word per response beat,
// starting one cycle after the request is accepted. Only one transaction is
// in flight at a time.
module kl_ram_target #(
  parameter int ABITS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] req_addr,
  input  logic        req_wen,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  input  logic [2:0]  req_size,
  input  logic [4:0]  req_srcid,
  input  logic        req_valid,
  output logic        req_ready,
  output logic [63:0] resp_rdata,
  output logic [2:0]  resp_size,
  output logic [4:0]  resp_dstid,
  output logic        resp_valid,
  input  logic        resp_ready
);

  localparam int DEPTH = 1 << ABITS;
  localparam logic [ABITS-1:0] IDX_ONE = ABITS'(1);

  typedef enum logic [1:0] {IDLE, WBURST, WACK, RBURST} state_t;

  state_t           state, state_nx;
  logic [63:0]      mem [DEPTH];
  logic [ABITS-1:0] idx;
  logic [ABITS-1:0] start_idx;
  logic [2:0]       remaining;
  logic [63:0]      rdata_p1;
  logic             req_take;
  logic             wr_en, rd_en;
  logic [ABITS-1:0] wr_idx, rd_idx;
  logic             unused_ok;

  assign start_idx = req_addr[ABITS+2:3];
  assign unused_ok = ^{req_addr[31:ABITS+3], req_addr[2:0]};
  // A request seen while reset is held must not touch the memory.
  assign req_take  = req_valid & ~rst;

  // Write acks carry zero data; only read beats expose the read register.
  assign resp_rdata = (state == RBURST) ? rdata_p1 : 64'd0;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state, handshake outputs and memory port controls.
  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    wr_en      = 1'b0;
    wr_idx     = idx;
    rd_en      = 1'b0;
    rd_idx     = idx;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_take) begin
          if (req_wen) begin
            wr_en    = 1'b1;
            wr_idx   = start_idx;
            state_nx = (req_size == 3'd0) ? WACK : WBURST;
          end else begin
            rd_en    = 1'b1;
            rd_idx   = start_idx;
            state_nx = RBURST;
          end
        end
      end
      WBURST: begin
        req_ready = 1'b1;
        if (req_take) begin
          wr_en = 1'b1;
          if (remaining == 3'd1) state_nx = WACK;
        end
      end
      WACK: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = IDLE;
      end
      RBURST: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          if (remaining == 3'd0) state_nx = IDLE;
          else                   rd_en    = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Burst bookkeeping: next word index, beats left and latched response tags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      remaining  <= 3'd0;
      resp_size  <= 3'd0;
      resp_dstid <= 5'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            idx        <= start_idx + IDX_ONE;
            remaining  <= req_size;
            resp_size  <= req_size;
            resp_dstid <= req_srcid;
          end
        end
        WBURST: begin
          if (req_valid) begin
            idx       <= idx + IDX_ONE;
            remaining <= remaining - 3'd1;
          end
        end
        RBURST: begin
          if (resp_ready && remaining != 3'd0) begin
            idx       <= idx + IDX_ONE;
            remaining <= remaining - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory array: byte-masked writes; registered read feeding the response (stage p1).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (req_wmask[b]) mem[wr_idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
    if (rd_en) rdata_p1 <= mem[rd_idx];
  end

endmodule

// File: tb/tb_kl_ram_target.sv
// tb_kl_ram_target: randomized scoreboard bench for kl_ram_target.
// The driver updates a word-array reference model and queues the expected
// response beats; a negedge monitor compares every presented response beat
// against the head of the queue and pops it on handshake.
module tb_kl_ram_target;

  localparam int ABITS = 10;
  localparam int DEPTH = 1 << ABITS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] req_addr = '0;
  logic        req_wen = 1'b0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wmask = '0;
  logic [2:0]  req_size = '0;
  logic [4:0]  req_srcid = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] resp_rdata;
  logic [2:0]  resp_size;
  logic [4:0]  resp_dstid;
  logic        resp_valid;
  logic        resp_ready = 1'b0;

  kl_ram_target #(.ABITS(ABITS)) dut (
    .clk(clk), .rst(rst),
    .req_addr(req_addr), .req_wen(req_wen), .req_wdata(req_wdata),
    .req_wmask(req_wmask), .req_size(req_size), .req_srcid(req_srcid),
    .req_valid(req_valid), .req_ready(req_ready),
    .resp_rdata(resp_rdata), .resp_size(resp_size), .resp_dstid(resp_dstid),
    .resp_valid(resp_valid), .resp_ready(resp_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic [2:0]  s;
    logic [4:0]  id;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] ref_mem [DEPTH];
  logic [63:0] wd [8];
  logic [7:0]  wm [8];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          hs_cyc = 0;
  int          mode = 0;
  int          stall_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // resp_ready pattern: 0 = always ready, 1 = random, 2 = three low cycles then one high.
  always @(posedge clk) begin
    #1;
    case (mode)
      0: resp_ready = 1'b1;
      1: resp_ready = 1'($urandom % 2);
      default: begin
        stall_cnt  = (stall_cnt + 1) % 4;
        resp_ready = (stall_cnt == 3);
      end
    endcase
  end

  // Monitor: every presented response beat must match the queue head.
  always @(negedge clk) begin
    chk("req_ready_excl", {63'd0, req_ready}, {63'd0, !resp_valid});
    if (resp_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_resp: got rdata 0x%0h dstid %0d, expected no response", resp_rdata, resp_dstid);
      end else begin
        chk("resp_rdata", resp_rdata, sb[0].d);
        chk("resp_size", {61'd0, resp_size}, {61'd0, sb[0].s});
        chk("resp_dstid", {59'd0, resp_dstid}, {59'd0, sb[0].id});
        if (resp_ready) begin
          void'(sb.pop_front());
          hs_cyc = cyc;
        end
      end
    end
  end

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 3) & (DEPTH - 1));
  endfunction

  task automatic model_write(input int ix, input logic [63:0] d, input logic [7:0] m);
    for (int b = 0; b < 8; b++)
      if (m[b]) ref_mem[ix][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic send_beat(input logic [31:0] a, input logic w, input logic [63:0] d,
                           input logic [7:0] m, input logic [2:0] s, input logic [4:0] id,
                           output bit ok);
    req_addr = a; req_wen = w; req_wdata = d; req_wmask = m;
    req_size = s; req_srcid = id; req_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        acc_cyc = cyc;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL req_accept_timeout: got req_ready 0 for 50 cycles, expected acceptance");
    end
  endtask

  // Wait for all queued beats while waving ignored requests at the DUT.
  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 400) begin
      @(posedge clk);
      #1;
      req_valid = 1'($urandom % 2);
      req_wen   = 1'($urandom % 2);
      req_addr  = $urandom;
      req_wdata = {$urandom, $urandom};
      req_wmask = 8'($urandom);
      req_size  = 3'($urandom);
      req_srcid = 5'($urandom);
      t++;
    end
    req_valid = 1'b0;
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL resp_timeout: got %0d beats outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [2:0] s, input logic [4:0] id);
    int ix = word_of(a);
    bit ok;
    exp_t e;
    for (int b = 0; b <= int'(s); b++) begin
      if (b == 0) send_beat(a, 1'b1, wd[b], wm[b], s, id, ok);
      else        send_beat($urandom, 1'($urandom), wd[b], wm[b], 3'($urandom), 5'($urandom), ok);
      if (!ok) return;
      model_write(ix, wd[b], wm[b]);
      ix = (ix + 1) % DEPTH;
    end
    req_valid = 1'b0;
    e.d = 64'd0; e.s = s; e.id = id;
    sb.push_back(e);
    wait_drain();
  endtask

  task automatic do_read(input logic [31:0] a, input logic [2:0] s, input logic [4:0] id);
    int ix = word_of(a);
    bit ok;
    exp_t e;
    send_beat(a, 1'b0, {$urandom, $urandom}, 8'($urandom), s, id, ok);
    req_valid = 1'b0;
    if (!ok) return;
    for (int b = 0; b <= int'(s); b++) begin
      e.d = ref_mem[(ix + b) % DEPTH]; e.s = s; e.id = id;
      sb.push_back(e);
    end
    wait_drain();
    if (mode == 0) chk("read_beat_timing", 64'(hs_cyc - acc_cyc), 64'(int'(s) + 1));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got no finish, expected bench completion");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    logic [31:0] a;
    logic [2:0]  s;
    logic [4:0]  id;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_resp_size", {61'd0, resp_size}, 64'd0);
    chk("rst_resp_dstid", {59'd0, resp_dstid}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1;

    // Clear the whole memory so every later read is fully predicted.
    mode = 0;
    for (int b = 0; b < 8; b++) begin wd[b] = 64'd0; wm[b] = 8'hFF; end
    for (int i = 0; i < DEPTH / 8; i++) do_write(32'(i * 64), 3'd7, 5'd1);

    // Single-beat write and read-back.
    wd[0] = 64'h1122334455667788; wm[0] = 8'hFF;
    do_write(32'h10, 3'd0, 5'd3);
    do_read(32'h10, 3'd0, 5'd7);

    // Partial byte mask over zero.
    wd[0] = 64'hAAAAAAAA_BBBBBBBB; wm[0] = 8'h0F;
    do_write(32'h18, 3'd0, 5'd4);
    chk("mask_model", ref_mem[3], 64'h00000000_BBBBBBBB);
    do_read(32'h18, 3'd0, 5'd5);

    // Four-beat write then back-to-back four-beat read.
    for (int b = 0; b < 4; b++) begin wd[b] = 64'(b + 1); wm[b] = 8'hFF; end
    do_write(32'h40, 3'd3, 5'd6);
    do_read(32'h40, 3'd3, 5'd8);

    // Wrap from the last word to word 0, for writes and reads.
    wd[0] = 64'hDEAD_0000_0000_03FF; wd[1] = 64'hBEEF_0000_0000_0000;
    wm[0] = 8'hFF; wm[1] = 8'hFF;
    do_write(32'h1FF8, 3'd1, 5'd9);
    chk("wrap_model", ref_mem[0], 64'hBEEF_0000_0000_0000);
    do_read(32'h1FF8, 3'd1, 5'd10);

    // Read with three stall cycles before every beat.
    mode = 2;
    do_read(32'h40, 3'd3, 5'd11);
    mode = 0;

    // Reset in the middle of an eight-beat write.
    for (int b = 0; b < 8; b++) begin wd[b] = 64'hA000 + 64'(b); wm[b] = 8'hFF; end
    do_write(32'h0, 3'd7, 5'd12);
    send_beat(32'h0, 1'b1, 64'hB000, 8'hFF, 3'd7, 5'd13, ok);
    if (ok) model_write(0, 64'hB000, 8'hFF);
    send_beat($urandom, 1'b1, 64'hB001, 8'hFF, 3'd0, 5'd0, ok);
    if (ok) model_write(1, 64'hB001, 8'hFF);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_resp_valid", {63'd0, resp_valid}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("postrst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("postrst_resp_dstid", {59'd0, resp_dstid}, 64'd0);
    @(posedge clk); #1;
    do_read(32'h0, 3'd7, 5'd14);

    // Randomized mix of reads and writes.
    for (int n = 0; n < 150; n++) begin
      mode = int'($urandom % 2);
      a    = $urandom;
      s    = 3'($urandom);
      id   = 5'($urandom);
      if ($urandom % 2) begin
        for (int b = 0; b < 8; b++) begin
          wd[b] = {$urandom, $urandom};
          wm[b] = ($urandom % 5 == 0) ? 8'h00 : 8'($urandom);
        end
        do_write(a, s, id);
      end else begin
        do_read(a, s, id);
      end
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/kl_ram_target.md
KL_RAM_TARGET -- requirements
Module: kl_ram_target

Interface
REQ-001 Parameter ABITS, default 10, log2 of memory depth in 64-bit words.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; one clock, reset is asynchronous and active-high.
REQ-004 req_addr  input  32  byte address; sampled on first beat only.
REQ-005 req_wen  input  1  1 = write, 0 = read; sampled on first beat.
REQ-006 req_wdata  input  64  write data, every write beat.
REQ-007 req_wmask  input  8  byte enables, bit i -> wdata[8i+7:8i].
REQ-008 req_size  input  3  burst code; beats = req_size+1 (1..8); sampled on first beat.
REQ-009 req_srcid  input  5  initiator id; sampled on first beat.
REQ-010 req_valid / req_ready  input / output  1 each  request handshake.
REQ-011 resp_rdata  output  64  read data; 0 on write ack.
REQ-012 resp_size  output  3  latched req_size of the transaction.
REQ-013 resp_dstid  output  5  latched req_srcid.
REQ-014 resp_valid / resp_ready  output / input  1 each  response handshake.

Function
REQ-015 Transfer on a channel occurs in a cycle where valid and ready are both 1.
REQ-016 Internal memory of 2^ABITS x 64 bits; word index = req_addr[ABITS+2:3]; addr[2:0] ignored.
REQ-017 Successive beats use index+1, wrapping modulo 2^ABITS (last word -> word 0).
REQ-018 States: IDLE, WBURST, WACK, RBURST; one transaction in flight at a time.
REQ-019 IDLE: req_ready=1, resp_valid=0.
REQ-020 IDLE, write beat accepted: write beat 0 under wmask that cycle; latch index+1, size, srcid, remaining=size; next WACK if size=0 else WBURST.
REQ-021 WBURST: req_ready=1, resp_valid=0; each accepted beat writes current index under its wmask, index++; req_addr/req_wen/req_size/req_srcid ignored; after the beat that makes remaining 0, next WACK.
REQ-022 WACK: req_ready=0, resp_valid=1, resp_rdata=0, resp_size/resp_dstid latched; on handshake next IDLE.
REQ-023 IDLE, read accepted: next RBURST; resp_valid=1 the following cycle with word at start index (1-cycle latency).
REQ-024 RBURST: req_ready=0; response fields held stable while resp_valid=1 and resp_ready=0.
REQ-025 RBURST beat handshake with beats remaining: next cycle presents next word, resp_valid stays 1 (back-to-back, no bubble).
REQ-026 RBURST handshake on last beat: next IDLE; resp_valid=0 next cycle; a new request can be accepted that cycle.
REQ-027 wmask=0 beat: handshake completes, memory unchanged, beat still counted.
REQ-028 Read after write: read issued after write ack returns the new data; no hazard window.
REQ-029 req_valid in WACK/RBURST: ignored, not accepted, no side effects.

Reset
REQ-030 rst=1: state IDLE, resp_valid=0, resp_rdata=0, resp_size=0, resp_dstid=0, req_ready=1 after release, counters cleared.
REQ-031 Reset mid-burst aborts transaction with no response; partially written words keep their values; memory never cleared.

Verification
REQ-032 Single write addr 0x10, wdata 0x1122334455667788, wmask 0xFF, size 0, srcid 3 -> one ack beat: rdata 0, size 0, dstid 3; read of 0x10 returns 0x1122334455667788.
REQ-033 Write 0x18, wmask 0x0F, wdata 0xAAAAAAAA_BBBBBBBB over 0 -> read returns 0x00000000_BBBBBBBB.
REQ-034 4-beat write (size 3) at 0x40 with 1,2,3,4, then size-3 read at 0x40 with resp_ready=1 -> 4 consecutive resp_valid cycles, data 1,2,3,4, size 3 each.
REQ-035 Size-1 read at last word (ABITS=10, addr 0x1FF8) -> beats from word 1023 then word 0 (wrap).
REQ-036 Read with resp_ready low 3 cycles per beat -> data held stable, req_ready=0 throughout, no beat lost/duplicated.
REQ-037 rst pulsed after beat 2 of a size-7 write -> no ack, resp_valid=0, req_ready=1; words 0-1 updated, rest unchanged.
